// File: rtl/exc_pkg.sv
// Shared constants, cause encodings and state type for the exception controller.
package exc_pkg;

   localparam int NUM_SRC = 4;

   // Handler entry points, zero-extended to the PC width at the point of use
   localparam logic [15:0] VEC_ILLEGAL = 16'h02BC;
   localparam logic [15:0] VEC_LS      = 16'h02E4;
   localparam logic [15:0] VEC_DIV0    = 16'h030C;
   localparam logic [15:0] VEC_ADDR    = 16'h0334;

   // Cause encoding equals the source index; lower index wins age ties
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
   localparam logic [1:0] CAUSE_LS      = 2'd1;
   localparam logic [1:0] CAUSE_DIV0    = 2'd2;
   localparam logic [1:0] CAUSE_ADDR    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_HANDLER = 2'd3
   } exc_state_e;

   // Maps a cause code onto its handler vector
   function automatic logic [15:0] cause_vector(input logic [1:0] cause_code);
      logic [15:0] vec;
      case (cause_code)
         CAUSE_ILLEGAL: vec = VEC_ILLEGAL;
         CAUSE_LS:      vec = VEC_LS;
         CAUSE_DIV0:    vec = VEC_DIV0;
         default:       vec = VEC_ADDR;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/exception_controller_if.sv
// Bundle of exception reports, commit/recovery information and redirect outputs.
interface exception_controller_if #(
   parameter int INST_NUM_W = 8,
   parameter int PC_W       = 32
);

   logic [3:0]              src_valid;
   logic [4*INST_NUM_W-1:0] src_inst_num;
   logic [4*PC_W-1:0]       src_pc;
   logic                    commit_valid;
   logic [INST_NUM_W-1:0]   commit_inst_num;
   logic                    mispredict_valid;
   logic [INST_NUM_W-1:0]   mispredict_inst_num;
   logic                    eret_valid;

   logic                    flush;
   logic                    redirect_valid;
   logic [PC_W-1:0]         redirect_pc;
   logic [PC_W-1:0]         epc;
   logic [1:0]              cause;
   logic                    exc_busy;
   logic                    double_fault;

   // Pipeline side: reports exceptions and commit progress, consumes redirects
   modport master (
      output src_valid, src_inst_num, src_pc,
      output commit_valid, commit_inst_num,
      output mispredict_valid, mispredict_inst_num,
      output eret_valid,
      input  flush, redirect_valid, redirect_pc, epc, cause, exc_busy, double_fault
   );

   // Controller side
   modport slave (
      input  src_valid, src_inst_num, src_pc,
      input  commit_valid, commit_inst_num,
      input  mispredict_valid, mispredict_inst_num,
      input  eret_valid,
      output flush, redirect_valid, redirect_pc, epc, cause, exc_busy, double_fault
   );

endinterface

// File: rtl/exc_oldest_sel.sv
// Picks the oldest valid candidate relative to a reference instruction number.
// Ages wrap modulo 2^INST_NUM_W; on equal age the lowest candidate index wins.
module exc_oldest_sel #(
   parameter int INST_NUM_W = 8,
   parameter int PC_W       = 32
) (
   input  logic [3:0]              cand_valid,
   input  logic [4*INST_NUM_W-1:0] cand_inst_num,
   input  logic [4*PC_W-1:0]       cand_pc,
   input  logic [INST_NUM_W-1:0]   ref_inst_num,
   output logic                    sel_valid,
   output logic [1:0]              sel_idx,
   output logic [INST_NUM_W-1:0]   sel_inst_num,
   output logic [PC_W-1:0]         sel_pc
);

   logic [INST_NUM_W-1:0] cand_age [4];
   logic [INST_NUM_W-1:0] best_age;

   // Age of each candidate as a plain wrapping subtract from the reference
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cand_age[i] = cand_inst_num[i*INST_NUM_W +: INST_NUM_W] - ref_inst_num;
      end
   end

   // Scan in priority order; strict less-than keeps the earlier index on a tie
   always_comb begin
      sel_valid    = 1'b0;
      sel_idx      = '0;
      sel_inst_num = '0;
      sel_pc       = '0;
      best_age     = '0;
      for (int i = 0; i < 4; i++) begin
         if (cand_valid[i] && (!sel_valid || (cand_age[i] < best_age))) begin
            sel_valid    = 1'b1;
            sel_idx      = 2'(i);
            best_age     = cand_age[i];
            sel_inst_num = cand_inst_num[i*INST_NUM_W +: INST_NUM_W];
            sel_pc       = cand_pc[i*PC_W +: PC_W];
         end
      end
   end

endmodule

// File: rtl/exception_controller.sv
// Holds the oldest pending exception, flushes and redirects to its handler once
// it commits, and masks new reports until ERET returns fetch to the saved EPC.
module exception_controller
   import exc_pkg::*;
#(
   parameter int INST_NUM_W = 8,
   parameter int PC_W       = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   exception_controller_if.slave bus
);

   exc_state_e            state_q, state_d;

   logic                  pend_valid_q, pend_valid_d;
   logic [INST_NUM_W-1:0] pend_inst_q, pend_inst_d;
   logic [PC_W-1:0]       pend_pc_q, pend_pc_d;
   logic [1:0]            pend_cause_q, pend_cause_d;

   logic                  flush_q, flush_d;
   logic                  redirect_valid_q, redirect_valid_d;
   logic [PC_W-1:0]       redirect_pc_q, redirect_pc_d;
   logic [PC_W-1:0]       epc_q, epc_d;
   logic [1:0]            cause_q, cause_d;
   logic                  busy_q, busy_d;
   logic                  double_fault_q, double_fault_d;

   logic [INST_NUM_W-1:0] src_age [4];
   logic [INST_NUM_W-1:0] mp_age;
   logic [INST_NUM_W-1:0] pend_age;
   logic [3:0]            src_alive;
   logic                  pend_keep;
   logic                  commit_hit;

   logic                  src_sel_valid;
   logic [1:0]            src_sel_idx;
   logic [INST_NUM_W-1:0] src_sel_inst;
   logic [PC_W-1:0]       src_sel_pc;

   logic                  merge_valid;
   logic [1:0]            merge_idx;
   logic [INST_NUM_W-1:0] merge_inst;
   logic [PC_W-1:0]       merge_pc;
   logic [1:0]            merge_cause;

   // Mispredict filtering: anything younger than the branch is killed this cycle
   always_comb begin
      mp_age     = bus.mispredict_inst_num - bus.commit_inst_num;
      pend_age   = pend_inst_q - bus.commit_inst_num;
      pend_keep  = pend_valid_q && !(bus.mispredict_valid && (pend_age > mp_age));
      commit_hit = bus.commit_valid && pend_valid_q && (bus.commit_inst_num == pend_inst_q);
      for (int i = 0; i < 4; i++) begin
         src_age[i]   = bus.src_inst_num[i*INST_NUM_W +: INST_NUM_W] - bus.commit_inst_num;
         src_alive[i] = bus.src_valid[i] && !(bus.mispredict_valid && (src_age[i] > mp_age));
      end
   end

   exc_oldest_sel #(
      .INST_NUM_W (INST_NUM_W),
      .PC_W       (PC_W)
   ) u_src_sel (
      .cand_valid    (src_alive),
      .cand_inst_num (bus.src_inst_num),
      .cand_pc       (bus.src_pc),
      .ref_inst_num  (bus.commit_inst_num),
      .sel_valid     (src_sel_valid),
      .sel_idx       (src_sel_idx),
      .sel_inst_num  (src_sel_inst),
      .sel_pc        (src_sel_pc)
   );

   // Pending entry sits in slot 0 so it survives an equal-age challenger
   exc_oldest_sel #(
      .INST_NUM_W (INST_NUM_W),
      .PC_W       (PC_W)
   ) u_merge_sel (
      .cand_valid    ({2'b00, src_sel_valid, pend_keep}),
      .cand_inst_num ({{(2*INST_NUM_W){1'b0}}, src_sel_inst, pend_inst_q}),
      .cand_pc       ({{(2*PC_W){1'b0}}, src_sel_pc, pend_pc_q}),
      .ref_inst_num  (bus.commit_inst_num),
      .sel_valid     (merge_valid),
      .sel_idx       (merge_idx),
      .sel_inst_num  (merge_inst),
      .sel_pc        (merge_pc)
   );

   assign merge_cause = (merge_idx == 2'd0) ? pend_cause_q : src_sel_idx;

   // Next-state and next-output decisions for the exception sequence
   always_comb begin
      state_d          = state_q;
      pend_valid_d     = pend_valid_q;
      pend_inst_d      = pend_inst_q;
      pend_pc_d        = pend_pc_q;
      pend_cause_d     = pend_cause_q;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      epc_d            = epc_q;
      cause_d          = cause_q;
      busy_d           = 1'b0;
      double_fault_d   = double_fault_q;

      case (state_q)
         ST_IDLE, ST_PENDING: begin
            if ((state_q == ST_PENDING) && commit_hit) begin
               state_d          = ST_FLUSH;
               flush_d          = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = PC_W'(cause_vector(pend_cause_q));
               epc_d            = pend_pc_q;
               cause_d          = pend_cause_q;
               pend_valid_d     = 1'b0;
            end else if (merge_valid) begin
               state_d      = ST_PENDING;
               pend_valid_d = 1'b1;
               pend_inst_d  = merge_inst;
               pend_pc_d    = merge_pc;
               pend_cause_d = merge_cause;
            end else begin
               state_d      = ST_IDLE;
               pend_valid_d = 1'b0;
            end
         end

         ST_FLUSH: begin
            state_d = ST_HANDLER;
            busy_d  = 1'b1;
         end

         ST_HANDLER: begin
            busy_d = 1'b1;
            if (|bus.src_valid) begin
               double_fault_d = 1'b1;
            end
            if (bus.eret_valid) begin
               state_d          = ST_IDLE;
               busy_d           = 1'b0;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = epc_q;
            end
         end

         default: begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
         end
      endcase
   end

   // State, pending entry and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         pend_valid_q     <= 1'b0;
         pend_inst_q      <= '0;
         pend_pc_q        <= '0;
         pend_cause_q     <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         epc_q            <= '0;
         cause_q          <= '0;
         busy_q           <= 1'b0;
         double_fault_q   <= 1'b0;
      end else begin
         state_q          <= state_d;
         pend_valid_q     <= pend_valid_d;
         pend_inst_q      <= pend_inst_d;
         pend_pc_q        <= pend_pc_d;
         pend_cause_q     <= pend_cause_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         epc_q            <= epc_d;
         cause_q          <= cause_d;
         busy_q           <= busy_d;
         double_fault_q   <= double_fault_d;
      end
   end

   assign bus.flush          = flush_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.epc            = epc_q;
   assign bus.cause          = cause_q;
   assign bus.exc_busy       = busy_q;
   assign bus.double_fault   = double_fault_q;

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Scheduler in front of the exception vector path. It collects exception reports from four sources: illegal-instruction, load/store, divide-by-zero and address fault.
- It keeps the single oldest pending exception by instruction number, relative to the commit pointer.
- It waits until that instruction reaches commit, then issues a one-cycle pipeline flush, redirects fetch to the handler vector and saves the EPC.
- It masks further exceptions until the handler returns (ERET), then redirects fetch back to the EPC.

Parameters:
- INST_NUM_W, 8, width of the instruction-number tag; the tag wraps modulo 2^INST_NUM_W.
- PC_W, 32, width of the PC and redirect address.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  4  exception request per source; bit0 illegal, bit1 LS, bit2 div0, bit3 address.
- src_inst_num  in  4*INST_NUM_W  instruction number per source; source i occupies slice i.
- src_pc  in  4*PC_W  faulting PC per source.
- commit_valid  in  1  an instruction commits this cycle.
- commit_inst_num  in  INST_NUM_W  number of the committing instruction; it is also the age reference.
- mispredict_valid  in  1  branch recovery; kills all instructions younger than mispredict_inst_num.
- mispredict_inst_num  in  INST_NUM_W  number of the mispredicted branch.
- eret_valid  in  1  handler return committed.
- flush  out  1  one-cycle pipeline flush pulse.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  PC_W  redirect target.
- epc  out  PC_W  saved faulting PC.
- cause  out  2  source index of the exception taken.
- exc_busy  out  1  high while in HANDLER.
- double_fault  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, state IDLE, pending register invalid.
- Age rule: age(x) = (x - commit_inst_num) mod 2^INST_NUM_W. Smaller age is older. Use an unsigned INST_NUM_W-bit subtract; no extra bits.
- Source selection, combinational each cycle: choose the valid source with the smallest age. On equal inst_num, fixed priority is illegal > LS > div0 > address.
- States: IDLE, PENDING, FLUSH, HANDLER.
- IDLE:
  - Any src_valid latches the selected source's inst_num, pc and cause, then goes to PENDING.
- PENDING:
  - A selected source replaces the pending entry only if its age is strictly smaller. On equal age, the pending entry stays.
  - mispredict_valid with age(pending) > age(mispredict_inst_num) discards the pending entry and returns to IDLE. Sources presented in that same cycle are evaluated after the discard, i.e. as in IDLE, and only if younger-than-branch sources are also killed.
    - A source whose age is <= age(mispredict) may be latched.
  - commit_valid with commit_inst_num == pending inst_num moves to FLUSH.
  - Commit match has priority over mispredict and over new sources in the same cycle; both are ignored.
- FLUSH, exactly one cycle:
  - flush = 1 and redirect_valid = 1.
  - redirect_pc = zero-extended vector for cause.
  - epc and cause are registered and stay stable until the next FLUSH.
  - Next state is HANDLER; exc_busy rises the following cycle.
  - Latency: commit match in cycle N gives flush/redirect registered outputs valid in cycle N+1.
- HANDLER:
  - exc_busy = 1.
  - Any src_valid sets double_fault; the report is dropped. double_fault stays set until reset.
  - eret_valid produces, in the next cycle, redirect_valid = 1 and redirect_pc = epc, with flush = 0, and returns to IDLE.
  - An exception in the same cycle as eret still sets double_fault and is dropped.
- Outside FLUSH and the ERET redirect cycle, flush and redirect_valid are 0. redirect_pc holds its last value.
- Reset asserted mid-operation returns immediately to IDLE with all outputs 0, including double_fault.

Decomposition:
- Package exc_pkg contains:
  - Vector constants: VEC_ILLEGAL = 16'h02BC, VEC_LS = 16'h02E4, VEC_DIV0 = 16'h030C, VEC_ADDR = 16'h0334.
  - Cause encodings 0–3.
  - State enum.
- Sub-module exc_oldest_sel: combinational 4-way age compare with tie priority. Outputs sel_valid, sel_idx, sel_inst_num and sel_pc. It is reused for the pending-replacement compare.

Test Plan:
- Basic path. commit_inst_num = 10. Div0 fires with inst_num = 12, pc = 0x100. Commit of 12 -> next cycle flush = 1, redirect_pc = 0x030C, epc = 0x100, cause = 2. One cycle later exc_busy = 1. eret_valid -> next cycle redirect_pc = 0x100, state IDLE.
- Oldest wins, with wrap. commit ref = 250. LS fires with inst_num = 3, then illegal fires with inst_num = 252. Pending becomes 252, since age 2 < age 9. Commit of 252 -> redirect_pc = 0x02BC.
- Tie. Illegal and address both fire in the same cycle with inst_num = 20 -> cause = 0, and the vector is 0x02BC on commit.
- Mispredict kill. Pending inst_num = 30, mispredict at 25 -> pending discarded, no flush when 30 appears at commit. Repeat with mispredict at 35 -> pending kept, flush occurs.
- Double fault. In HANDLER, LS fires -> double_fault = 1, no flush. Eret in the same cycle as an address report -> redirect to epc, double_fault stays 1.
- Reset in HANDLER. rst_n drops -> all outputs 0 immediately. After release, a new exception is serviced normally.
